// File: rtl/mode_register_if.sv
// Bus bundle for mode_register: operation controls in, registered value and flags out.
interface mode_register_if #(
  parameter int WIDTH = 10
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             carry;
  logic             zero;

  modport master (
    output en, mode, din, sin,
    input  dout, carry, zero
  );

  modport slave (
    input  en, mode, din, sin,
    output dout, carry, zero
  );
endinterface

// File: rtl/mode_register.sv
// Mode-controlled datapath register: load, count up/down (wrap or saturate),
// shift, rotate and arithmetic shift, with carry/borrow and zero flags.
module mode_register #(
  parameter int               WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter bit               SATURATE    = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_reset,
  mode_register_if.slave bus
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_INC  = 3'b010;
  localparam logic [2:0] MODE_DEC  = 3'b011;
  localparam logic [2:0] MODE_SHL  = 3'b100;
  localparam logic [2:0] MODE_SHR  = 3'b101;
  localparam logic [2:0] MODE_ROL  = 3'b110;
  localparam logic [2:0] MODE_ASR  = 3'b111;

  localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_dout;
  logic             r_carry;
  logic [WIDTH-1:0] w_dout_next;
  logic             w_carry_next;
  logic             w_at_max;
  logic             w_at_min;

  assign w_at_max = (r_dout == ALL_ONES);
  assign w_at_min = (r_dout == ALL_ZEROS);

  // Next value and carry for the selected operation; en=0 holds both.
  always_comb begin
    w_dout_next  = r_dout;
    w_carry_next = r_carry;
    if (bus.en) begin
      case (bus.mode)
        MODE_HOLD: begin
          w_dout_next  = r_dout;
          w_carry_next = r_carry;
        end
        MODE_LOAD: begin
          w_dout_next  = bus.din;
          w_carry_next = 1'b0;
        end
        MODE_INC: begin
          // Saturating INC pins at all-ones but still flags the overflow attempt.
          if (w_at_max && SATURATE) begin
            w_dout_next = ALL_ONES;
          end else begin
            w_dout_next = r_dout + ONE;
          end
          w_carry_next = w_at_max;
        end
        MODE_DEC: begin
          if (w_at_min && SATURATE) begin
            w_dout_next = ALL_ZEROS;
          end else begin
            w_dout_next = r_dout - ONE;
          end
          w_carry_next = w_at_min;
        end
        MODE_SHL: begin
          w_dout_next  = {r_dout[WIDTH-2:0], bus.sin};
          w_carry_next = r_dout[WIDTH-1];
        end
        MODE_SHR: begin
          w_dout_next  = {bus.sin, r_dout[WIDTH-1:1]};
          w_carry_next = r_dout[0];
        end
        MODE_ROL: begin
          w_dout_next  = {r_dout[WIDTH-2:0], r_dout[WIDTH-1]};
          w_carry_next = r_dout[WIDTH-1];
        end
        MODE_ASR: begin
          w_dout_next  = {r_dout[WIDTH-1], r_dout[WIDTH-1:1]};
          w_carry_next = r_dout[0];
        end
        default: begin
          w_dout_next  = r_dout;
          w_carry_next = r_carry;
        end
      endcase
    end else begin
      w_dout_next  = r_dout;
      w_carry_next = r_carry;
    end
  end

  // State register with synchronous reset taking priority over any operation.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dout  <= RESET_VALUE;
      r_carry <= 1'b0;
    end else begin
      r_dout  <= w_dout_next;
      r_carry <= w_carry_next;
    end
  end

  assign bus.dout  = r_dout;
  assign bus.carry = r_carry;
  assign bus.zero  = (r_dout == ALL_ZEROS);

endmodule
